wormhole_out_chan_arbiter: RTL and testbench
============================================

// Module: wormhole_out_chan_arbiter
// PURPOSE
//  Per-output-channel arbiter for the 2D-mesh wormhole node; one instance per output port.
//  Picks one input VC whose HEAD flit routes to this output and locks the output to it until TAIL.
//  Priority: highest hop count, round-robin among equal hop counts, with age-based anti-starvation.
//  Drives crossbar select, per-VC grant and output valid.
// PARAMETERS
//  IN_N       5  number of input VCs (>=2)
//  FLIT_ID_W  2  flit type field width
//  HOP_CNT_W  4  hop count field width
//  AGE_W      4  per-input wait counter width; AGE_MAX = 2**AGE_W-1
// PORTS
//  clk_i        in   1                    clock
//  rst_ni       in   1                    async active-low reset
//  req_i        in   IN_N                 VC i route result valid and targets this output
//  data_vld_i   in   IN_N                 VC i has a flit at its head
//  flit_id_i    in   IN_N*FLIT_ID_W       flit type of VC i head flit, packed [i*FLIT_ID_W +: FLIT_ID_W]
//  hop_cnt_i    in   IN_N*HOP_CNT_W       hop count of VC i current packet, packed likewise
//  fwd_rdy_i    in   1                    downstream FIFO not full
//  sel_o        out  $clog2(IN_N)         crossbar select (owner index)
//  chan_alloc_o out  IN_N                 one-hot grant to owner VC (flit popped when pulsed with out_vld_o)
//  out_vld_o    out  1                    output write enable
//  locked_o     out  1                    output held by a packet
// BEHAVIOUR
//  Flit IDs: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11 (single-flit packet).
//  Reset (async, rst_ni=0): state=IDLE, owner=0, rr_ptr=0, all ages=0; sel_o=0, chan_alloc_o=0, out_vld_o=0, locked_o=0.
//  cand[i] = req_i[i] & data_vld_i[i] & flit_id in {HEAD, HEAD_TAIL}.
//  IDLE: chan_alloc_o=0, out_vld_o=0, sel_o holds last owner. If any cand:
//   - if any cand has age==AGE_MAX: winner = first such index scanning from rr_ptr upward (mod IN_N);
//   - else winner = cand with max hop_cnt (unsigned); ties -> first scanning from rr_ptr.
//   - registered: next cycle state=LOCKED, owner=winner. Arbitration-to-grant latency 1 cycle.
//  LOCKED: sel_o=owner, chan_alloc_o=onehot(owner), locked_o=1,
//   out_vld_o = data_vld_i[owner] & fwd_rdy_i (combinational; flit moves same cycle).
//   - transfer with flit_id TAIL or HEAD_TAIL -> IDLE next cycle, rr_ptr=(owner+1) mod IN_N, age[owner]=0.
//   - lock is released ONLY by a transferred TAIL/HEAD_TAIL; req_i/data_vld_i dropping mid-packet
//     (VC empty, bubbles) keeps LOCKED with out_vld_o=0.
//   - fwd_rdy_i=0: out_vld_o=0, no pop, state held (backpressure).
//  Ages: each cycle, age[i] increments (saturating at AGE_MAX) when cand[i] and i is not the granted
//   owner; cleared when i wins arbitration; cleared when req_i[i]=0. Ages update in LOCKED too.
//  Back-to-back packets: one idle cycle between TAIL transfer and next grant (max 1 flit / cycle otherwise).
//  HEAD seen while LOCKED on the owner VC (malformed) is forwarded as body; no lock change.
//  Async reset mid-packet: immediately back to reset values; partial packet is the upstream's concern.
//  Width rules: hop_cnt compared unsigned full width; rr_ptr and owner wrap at IN_N (not 2**width).
// TESTING
//  1 Reset: rst_ni=0 while LOCKED -> same-cycle chan_alloc_o=0, out_vld_o=0, locked_o=0, sel_o=0.
//  2 Hop priority: IDLE, cand 1 (hop 3) and 4 (hop 7) -> next cycle sel_o=4, chan_alloc_o=5'b10000;
//    3-flit packet with fwd_rdy_i=1 -> out_vld_o high 3 cycles, IDLE after TAIL, rr_ptr=0.
//  3 Round-robin: inputs 0,2 HEAD, hop 2 both, repeated 1-flit HEAD_TAIL packets ->
//    grants alternate 0,2,0,2 with 1 idle cycle between each.
//  4 Backpressure: LOCKED owner 1, fwd_rdy_i low 4 cycles mid-packet -> out_vld_o=0, chan_alloc_o=5'b00010,
//    locked_o=1 held; resumes with no flit lost/duplicated.
//  5 Starvation (AGE_W=2): input 0 hop 0 vs input 3 hop 9 continuously -> input 0 wins once its age hits 3,
//    within 4 arbitrations; age[0] then 0.
//  6 Lock hold: owner's data_vld_i drops 2 cycles before TAIL while input 2 requests HEAD -> no switch;
//    input 2 granted only after TAIL transfer.

Source files
------------

// File: rtl/wormhole_out_chan_arbiter.sv
// Output-channel arbiter for a 2D-mesh wormhole router node: grants one input VC per packet,
// preferring the highest hop count, round-robin on ties, with age-based anti-starvation.
module wormhole_out_chan_arbiter #(
  parameter int IN_N      = 5,
  parameter int FLIT_ID_W = 2,
  parameter int HOP_CNT_W = 4,
  parameter int AGE_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [IN_N-1:0]              req_i,
  input  logic [IN_N-1:0]              data_vld_i,
  input  logic [IN_N*FLIT_ID_W-1:0]    flit_id_i,
  input  logic [IN_N*HOP_CNT_W-1:0]    hop_cnt_i,
  input  logic                         fwd_rdy_i,
  output logic [$clog2(IN_N)-1:0]      sel_o,
  output logic [IN_N-1:0]              chan_alloc_o,
  output logic                         out_vld_o,
  output logic                         locked_o
);

  localparam int SEL_W = $clog2(IN_N);
  localparam logic [AGE_W-1:0]     AGE_MAX = '1;
  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_HT   = FLIT_ID_W'(3);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       owner_q, owner_d;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [AGE_W-1:0]       age_q [IN_N];
  logic [AGE_W-1:0]       age_d [IN_N];

  logic [FLIT_ID_W-1:0]   flit_a [IN_N];
  logic [HOP_CNT_W-1:0]   hop_a  [IN_N];
  logic [IN_N-1:0]        cand;
  logic                   win_vld;
  logic [SEL_W-1:0]       win_idx;
  logic                   tail_xfer;

  // Index arithmetic wraps at IN_N, which need not be a power of two.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= IN_N) s = s - IN_N;
    return SEL_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      flit_a[i] = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
      hop_a[i]  = hop_cnt_i[i*HOP_CNT_W +: HOP_CNT_W];
      cand[i]   = req_i[i] & data_vld_i[i] & ((flit_a[i] == ID_HEAD) | (flit_a[i] == ID_HT));
    end
  end

  // Scan from rr_ptr so the first hit wins ties; a saturated age overrides hop priority.
  always_comb begin
    logic                 old_found;
    logic [SEL_W-1:0]     old_idx;
    logic                 best_found;
    logic [HOP_CNT_W-1:0] best_hop;
    logic [SEL_W-1:0]     best_idx;
    logic [SEL_W-1:0]     idx;
    old_found  = 1'b0;
    old_idx    = '0;
    best_found = 1'b0;
    best_hop   = '0;
    best_idx   = '0;
    idx        = '0;
    for (int k = 0; k < IN_N; k++) begin
      idx = wrap_add(rr_ptr_q, k);
      if (cand[idx]) begin
        if (!old_found && (age_q[idx] == AGE_MAX)) begin
          old_found = 1'b1;
          old_idx   = idx;
        end
        if (!best_found || (hop_a[idx] > best_hop)) begin
          best_found = 1'b1;
          best_hop   = hop_a[idx];
          best_idx   = idx;
        end
      end
    end
    win_vld = best_found;
    win_idx = old_found ? old_idx : best_idx;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    chan_alloc_o = '0;
    out_vld_o    = 1'b0;
    locked_o     = 1'b0;
    tail_xfer    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_LOCKED;
          owner_d = win_idx;
        end
      end
      ST_LOCKED: begin
        locked_o     = 1'b1;
        chan_alloc_o = IN_N'(1) << owner_q;
        out_vld_o    = data_vld_i[owner_q] & fwd_rdy_i;
        // Only a transferred tail releases the lock; a stray HEAD is forwarded as body.
        tail_xfer    = out_vld_o & ((flit_a[owner_q] == ID_TAIL) | (flit_a[owner_q] == ID_HT));
        if (tail_xfer) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_add(owner_q, 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      age_d[i] = age_q[i];
      if (!req_i[i]) begin
        age_d[i] = '0;
      end else if ((state_q == ST_IDLE) && win_vld && (win_idx == SEL_W'(i))) begin
        age_d[i] = '0;
      end else if ((state_q == ST_LOCKED) && (owner_q == SEL_W'(i))) begin
        if (tail_xfer) age_d[i] = '0;
      end else if (cand[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < IN_N; i++) age_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < IN_N; i++) age_q[i] <= age_d[i];
    end
  end

  assign sel_o = owner_q;

endmodule

// File: tb/tb_wormhole_out_chan_arbiter.sv
// Directed bench: per-VC flit sources feed the arbiter; every forwarded flit is matched in order
// against a scoreboard of expected {vc, flit} entries, plus cycle-level checks of grant behaviour.
module tb_wormhole_out_chan_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  req_i;
  logic [4:0]  data_vld_i;
  logic [9:0]  flit_id_i;
  logic [19:0] hop_cnt_i;
  logic        fwd_rdy_i;
  logic [2:0]  sel_o;
  logic [4:0]  chan_alloc_o;
  logic        out_vld_o;
  logic        locked_o;

  wormhole_out_chan_arbiter #(
    .IN_N(5), .FLIT_ID_W(2), .HOP_CNT_W(4), .AGE_W(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_vld_i(data_vld_i),
    .flit_id_i(flit_id_i), .hop_cnt_i(hop_cnt_i), .fwd_rdy_i(fwd_rdy_i),
    .sel_o(sel_o), .chan_alloc_o(chan_alloc_o), .out_vld_o(out_vld_o), .locked_o(locked_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  src_mem [5][32];
  int          src_rd [5];
  int          src_wr [5];
  logic [3:0]  hop [5];
  logic [4:0]  req_en;
  logic [4:0]  vld_en;
  logic [10:0] exp_q [$];
  int          tag_n = 0;
  int          vld_cnt [5];
  logic [15:0] hist;
  logic        o_vld;
  logic        o_lock;
  logic [4:0]  o_alloc;
  logic [2:0]  o_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [7:0] head;
    logic       ne;
    for (int i = 0; i < 5; i++) begin
      ne   = (src_rd[i] != src_wr[i]);
      head = ne ? src_mem[i][src_rd[i]] : 8'h00;
      req_i[i]            = ne & req_en[i];
      data_vld_i[i]       = ne & vld_en[i];
      flit_id_i[i*2 +: 2] = head[1:0];
      hop_cnt_i[i*4 +: 4] = hop[i];
    end
  endtask

  task automatic push_flit(input int vc, input logic [1:0] id);
    logic [7:0] f;
    f = {tag_n[5:0], id};
    src_mem[vc][src_wr[vc]] = f;
    src_wr[vc]++;
    exp_q.push_back({vc[2:0], f});
    tag_n++;
    drive();
  endtask

  task automatic load_pkt(input int vc, input int n);
    for (int j = 0; j < n; j++) begin
      if (n == 1)          push_flit(vc, 2'b11);
      else if (j == 0)     push_flit(vc, 2'b10);
      else if (j == n - 1) push_flit(vc, 2'b01);
      else                 push_flit(vc, 2'b00);
    end
  endtask

  task automatic step();
    logic [7:0]  cur;
    logic [4:0]  oh;
    logic [10:0] e;
    @(negedge clk_i);
    o_vld   = out_vld_o;
    o_alloc = chan_alloc_o;
    o_sel   = sel_o;
    o_lock  = locked_o;
    hist    = {hist[14:0], out_vld_o};
    if (out_vld_o) begin
      cur = 8'hFF;
      if (sel_o < 3'd5) begin
        vld_cnt[sel_o]++;
        if (src_rd[sel_o] != src_wr[sel_o]) cur = src_mem[sel_o][src_rd[sel_o]];
      end
      oh = 5'b00001 << sel_o;
      chk("alloc_onehot", chan_alloc_o, oh);
      if (exp_q.size() == 0) begin
        chk("sb_extra_flit", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_flit", {sel_o, cur}, e);
      end
    end
    @(posedge clk_i);
    #1;
    if (o_vld && (o_sel < 3'd5)) begin
      if (src_rd[o_sel] != src_wr[o_sel]) src_rd[o_sel]++;
    end
    drive();
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    fwd_rdy_i = 1'b1;
    req_en    = '1;
    vld_en    = '1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      src_rd[i]  = 0;
      src_wr[i]  = 0;
      hop[i]     = '0;
      vld_cnt[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 80)) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    hist = '0;
    rst_ni = 1'b0;
    do_reset();
    chk("rst_sel", sel_o, 0);
    chk("rst_alloc", chan_alloc_o, 0);
    chk("rst_vld", out_vld_o, 0);
    chk("rst_lock", locked_o, 0);

    // Hop priority: VC4 (hop 7) beats VC1 (hop 3); VC1 follows after the idle cycle.
    do_reset();
    hop[1] = 4'd3;
    hop[4] = 4'd7;
    load_pkt(4, 3);
    load_pkt(1, 1);
    step();
    chk("t2_arb_alloc", o_alloc, 0);
    chk("t2_arb_lock", o_lock, 0);
    step();
    chk("t2_sel", o_sel, 4);
    chk("t2_alloc", o_alloc, 5'b10000);
    chk("t2_vld", o_vld, 1);
    chk("t2_lock", o_lock, 1);
    drain("t2_drain");
    step();
    chk("t2_idle_lock", o_lock, 0);
    chk("t2_idle_vld", o_vld, 0);
    chk("t2_vc4_flits", vld_cnt[4], 3);

    // Round-robin between equal-hop VC0 and VC2 with single-flit packets.
    do_reset();
    hop[0] = 4'd2;
    hop[2] = 4'd2;
    load_pkt(0, 1);
    load_pkt(2, 1);
    load_pkt(0, 1);
    load_pkt(2, 1);
    hist = '0;
    repeat (8) step();
    chk("t3_vld_pattern", hist[7:0], 8'h55);
    drain("t3_drain");

    // Backpressure for 4 cycles mid-packet on owner VC1.
    do_reset();
    hop[1] = 4'd5;
    load_pkt(1, 6);
    repeat (3) step();
    fwd_rdy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_bp_vld", o_vld, 0);
      chk("t4_bp_alloc", o_alloc, 5'b00010);
      chk("t4_bp_lock", o_lock, 1);
    end
    fwd_rdy_i = 1'b1;
    drain("t4_drain");
    step();
    chk("t4_end_lock", o_lock, 0);
    chk("t4_vc1_flits", vld_cnt[1], 6);

    // Lock hold through bubbles, stray HEAD forwarded as body, VC2 waits for the tail.
    do_reset();
    hop[0] = 4'd1;
    push_flit(0, 2'b10);
    push_flit(0, 2'b10);
    push_flit(0, 2'b00);
    push_flit(0, 2'b01);
    step();
    step();
    hop[2]    = 4'd9;
    req_en[0] = 1'b0;
    vld_en[0] = 1'b0;
    load_pkt(2, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t6_bub_vld", o_vld, 0);
      chk("t6_bub_lock", o_lock, 1);
      chk("t6_bub_sel", o_sel, 0);
    end
    req_en[0] = 1'b1;
    vld_en[0] = 1'b1;
    drive();
    drain("t6_drain");

    // Starvation: VC0 (hop 0) must win once its age saturates, then age restarts.
    do_reset();
    hop[0] = 4'd0;
    hop[3] = 4'd9;
    load_pkt(3, 1);
    load_pkt(3, 1);
    load_pkt(0, 1);
    load_pkt(3, 1);
    load_pkt(3, 1);
    load_pkt(0, 1);
    drain("t5_drain");
    chk("t5_vc0_flits", vld_cnt[0], 2);

    // Asynchronous reset while locked on VC2.
    do_reset();
    hop[2] = 4'd4;
    load_pkt(2, 4);
    step();
    step();
    chk("t1_pre_lock", o_lock, 1);
    chk("t1_pre_sel", o_sel, 2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t1_rst_alloc", chan_alloc_o, 0);
    chk("t1_rst_vld", out_vld_o, 0);
    chk("t1_rst_lock", locked_o, 0);
    chk("t1_rst_sel", sel_o, 0);
    do_reset();
    step();
    chk("t1_post_lock", o_lock, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
